// File: rtl/acquisition_controller.sv
// acquisition_controller: sequences ping-pong sample capture (pre/post trigger counts,
// trigger latch strobe, bank swap once the display has released the locked frame).
module acquisition_controller #(
  parameter int LOG_SAMPLES = 12,
  parameter int TIMEOUT_WIDTH = 24,
  parameter logic [TIMEOUT_WIDTH-1:0] AUTO_TIMEOUT = 24'd1_000_000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   sampleReady,
  input  logic                   triggerDetected,
  input  logic [1:0]             mode,
  input  logic                   arm,
  input  logic [LOG_SAMPLES-1:0] postTriggerSamples,
  input  logic                   displayDone,
  output logic                   activeBramSelect,
  output logic                   disableCollection,
  output logic                   isTrigger,
  output logic                   frameReady,
  output logic                   frameTriggered,
  output logic [2:0]             state
);
  typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
  localparam logic [1:0] M_AUTO = 2'd0, M_SINGLE = 2'd2, M_STOP = 2'd3;
  localparam logic [LOG_SAMPLES:0] FULL = {1'b1, {LOG_SAMPLES{1'b0}}};
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = AUTO_TIMEOUT - 1'b1;
  state_t st;
  logic [LOG_SAMPLES:0] sample_count, count_inc, fill_target, post_ext;
  logic [LOG_SAMPLES-1:0] post_latched;
  logic [TIMEOUT_WIDTH-1:0] timeout;
  logic auto_fire, trig_src, display_busy, write, is_auto;
  assign state = st;
  assign disableCollection = (st == IDLE) | (st == DONE);
  assign write = sampleReady & ~disableCollection;
  assign is_auto = mode == M_AUTO;
  assign isTrigger = (st == ARMED) & write & (triggerDetected | (auto_fire & is_auto));
  assign count_inc = sample_count + 1'b1;
  assign post_ext = {1'b0, post_latched};
  assign fill_target = FULL - post_ext;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      activeBramSelect <= 1'b0;
      frameReady <= 1'b0;
      frameTriggered <= 1'b0;
      sample_count <= '0;
      post_latched <= '0;
      timeout <= '0;
      auto_fire <= 1'b0;
      trig_src <= 1'b0;
      display_busy <= 1'b0;
    end else begin
      frameReady <= 1'b0;
      if (displayDone) display_busy <= 1'b0;
      if (st != ARMED) begin
        timeout <= '0;
        auto_fire <= 1'b0;
      end
      if (mode == M_STOP) st <= IDLE;
      else case (st)
        IDLE: if (mode != M_SINGLE || arm) begin
          st <= FILL;
          post_latched <= postTriggerSamples;
          sample_count <= '0;
        end
        FILL: if (write) begin
          sample_count <= count_inc;
          if (count_inc == fill_target) st <= ARMED;
        end
        ARMED: begin
          if (is_auto) begin
            if (timeout == TIMEOUT_LAST) auto_fire <= 1'b1;
            else timeout <= timeout + 1'b1;
          end
          if (isTrigger) begin
            st <= POST;
            sample_count <= '0;
            trig_src <= triggerDetected;
          end
        end
        POST: if (sample_count == post_ext) st <= DONE;
        else if (write) begin
          sample_count <= count_inc;
          if (count_inc == post_ext) st <= DONE;
        end
        DONE: if (!display_busy || displayDone) begin
          activeBramSelect <= ~activeBramSelect;
          frameReady <= 1'b1;
          display_busy <= 1'b1;
          frameTriggered <= trig_src;
          if (mode == M_SINGLE) st <= IDLE;
          else begin
            st <= FILL;
            post_latched <= postTriggerSamples;
            sample_count <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
